// File: rtl/f1_reaction_timer_if.sv
// Light-bar / button / score bundle between the start-light sequencer side and the reaction timer.
// The master drives tick, lights and btn; the slave (the timer) drives the results.
interface f1_reaction_timer_if #(
  parameter int CNT_W = 16
);
  logic             tick;
  logic [7:0]       lights;
  logic             btn;
  logic [CNT_W-1:0] time_out;
  logic             valid;
  logic             timeout;
  logic             jump_start;
  logic [CNT_W-1:0] best_time;
  logic             busy;

  modport master (
    output tick, lights, btn,
    input  time_out, valid, timeout, jump_start, best_time, busy
  );

  modport slave (
    input  tick, lights, btn,
    output time_out, valid, timeout, jump_start, best_time, busy
  );
endinterface

// File: rtl/f1_reaction_timer.sv
// Measures lights-out to button-press time in ticks, flags jump starts and timeouts, tracks best time.
// All outputs registered: results appear the cycle after the deciding edge; no back-pressure.
module f1_reaction_timer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 2000
) (
  input  logic              clk,
  input  logic              rst,
  f1_reaction_timer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_ALL_ON,
    S_TIMING,
    S_JUMP
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] time_out_q, time_out_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             jump_q, jump_d;
  logic             busy_q, busy_d;
  logic             btn_q, btn_d;

  logic             press;
  logic             lights_all;
  logic             lights_off;
  logic [CNT_W-1:0] cnt_inc;

  assign press      = bus.btn & ~btn_q;
  assign lights_all = (bus.lights == 8'hFF);
  assign lights_off = (bus.lights == 8'h00);
  assign cnt_inc    = cnt_q + ONE_C;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    time_out_d = time_out_q;
    best_d     = best_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    btn_d      = bus.btn;

    case (state_q)
      S_IDLE: begin
        if (lights_all) begin
          state_d = S_ALL_ON;
        end else if (!lights_off) begin
          state_d = S_BUILD;
        end
      end
      S_BUILD: begin
        if (press) begin
          state_d = S_JUMP;
        end else if (lights_all) begin
          state_d = S_ALL_ON;
        end else if (lights_off) begin
          state_d = S_IDLE;
        end
      end
      S_ALL_ON: begin
        // Partial patterns while fully lit are glitches from the sequencer; hold.
        if (press) begin
          state_d = S_JUMP;
        end else if (lights_off) begin
          state_d = S_TIMING;
          cnt_d   = '0;
        end
      end
      S_TIMING: begin
        // A press reports the count before any same-cycle tick is applied.
        if (press) begin
          time_out_d = cnt_q;
          valid_d    = 1'b1;
          if (cnt_q < best_q) begin
            best_d = cnt_q;
          end
          state_d = S_IDLE;
        end else if (bus.tick) begin
          if (cnt_inc == TIMEOUT_C) begin
            time_out_d = TIMEOUT_C;
            timeout_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_JUMP: begin
        if (lights_off && !bus.btn) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    jump_d = (state_d == S_JUMP);
    busy_d = (state_d == S_BUILD) || (state_d == S_ALL_ON) || (state_d == S_TIMING);
  end

  // btn_q resets high so a button held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      time_out_q <= '0;
      best_q     <= '1;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      jump_q     <= 1'b0;
      busy_q     <= 1'b0;
      btn_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      time_out_q <= time_out_d;
      best_q     <= best_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      jump_q     <= jump_d;
      busy_q     <= busy_d;
      btn_q      <= btn_d;
    end
  end

  assign bus.time_out   = time_out_q;
  assign bus.valid      = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.jump_start = jump_q;
  assign bus.best_time  = best_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/f1_reaction_timer.md
# f1_reaction_timer

Consumer end of the F1 start-light sequence. Watches the 8-bit light bar produced by the light sequencer and the player's button, and measures reaction time from lights-out to button press in `tick` periods. Detects jump starts (press before lights-out) and no-response timeouts, and keeps the best valid time since reset. Sits beside the light sequencer and drives the score display.

## Interface

**Parameters**
- `CNT_W`, default 16: reaction counter and result width.
- `TIMEOUT`, default 2000: tick count at which an unanswered run is abandoned. Must be ≥1 and < 2^CNT_W.

**Ports**
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-high.
- `tick` in, 1: one-cycle timebase strobe (1 ms in the system); may be high on consecutive cycles.
- `lights` in, 8: light bar from the sequencer; already synchronous to `clk`.
- `btn` in, 1: player button level; already synchronised and debounced.
- `time_out` out, CNT_W: last reported reaction time in ticks; held until the next report.
- `valid` out, 1: one-cycle pulse when `time_out` is updated by a good reaction.
- `timeout` out, 1: one-cycle pulse when a run times out.
- `jump_start` out, 1: level, high while in JUMP.
- `best_time` out, CNT_W: minimum valid `time_out` since reset.
- `busy` out, 1: high in BUILD, ALL_ON and TIMING.

## Operation

**Press detection**
- `press = btn & ~btn_q`, where `btn_q` is `btn` registered.
- `btn_q` resets to 1, so a button held through reset never produces a press.

**States** (`cnt` is the internal CNT_W counter)
- IDLE:
  - `lights == 0`: stay.
  - `lights != 0` and not 8'hFF: go to BUILD.
  - `lights == 8'hFF`: go to ALL_ON.
  - Presses are ignored.
- BUILD:
  - `press`: go to JUMP.
  - else `lights == 8'hFF`: go to ALL_ON.
  - else `lights == 0`: go to IDLE (sequence aborted, no output).
- ALL_ON:
  - `press`: go to JUMP. Press wins even if `lights == 0` in the same cycle.
  - else `lights == 0`: go to TIMING with `cnt` cleared to 0.
  - Any value other than 8'hFF or 0 is held as ALL_ON.
- TIMING:
  - `press`: register `time_out = cnt`, pulse `valid`, set `best_time = min(best_time, cnt)`, go to IDLE.
  - else `tick` and `cnt+1 == TIMEOUT`: register `time_out = TIMEOUT`, pulse `timeout`, go to IDLE. `best_time` is unchanged.
  - else `tick`: `cnt = cnt + 1`.
  - Press beats tick and timeout in the same cycle; the reported value is `cnt` before the increment.
- JUMP:
  - `jump_start` is high.
  - Go to IDLE only when `lights == 0` and `btn == 0` in the same cycle.
  - `time_out` and `best_time` are unchanged.

**Arithmetic**
- `cnt` cannot exceed TIMEOUT, so it never wraps.
- The `best_time` comparison is unsigned; ties leave it unchanged.

**Reset values**
- State IDLE, `cnt` 0, `time_out` 0.
- `valid`, `timeout`, `jump_start`, `busy` all 0.
- `best_time` all ones.
- `btn_q` 1.
- Reset mid-run discards the run and produces no pulse.

## Timing

- All outputs are registered.
- A press sampled at edge k in TIMING gives `valid` and the new `time_out` / `best_time` in the cycle after edge k, for exactly one cycle.
- The timeout pulse follows the same rule.
- The ALL_ON-to-TIMING transition occurs at the first edge that samples `lights == 0`. `cnt` is 0 from the next cycle. A tick in that same cycle is not counted.
- `jump_start` rises the cycle after the press edge. It falls the cycle after the exit condition is sampled.
- `busy` mirrors the state: it is high the cycle after entering BUILD, ALL_ON or TIMING.
- No back-pressure: `valid` is not held for a consumer.
- Minimum spacing between reports is 3 cycles: IDLE, then ALL_ON, then TIMING.

## Test plan

- **Normal run.** Step `lights` 01, 03 … FF, then 00. Issue 250 ticks, then a press.
  - `valid` pulses once with `time_out = 250`.
  - `best_time = 250`, `busy` low afterward.
- **Best tracking.** Three normal runs with reaction times 300, 120, 180.
  - `time_out` ends at 180.
  - `best_time` goes 300, then 120, and stays 120.
- **Jump start.** Press while `lights = 8'h1F`.
  - `jump_start` goes high. No `valid` pulse; `time_out` is unchanged.
  - `jump_start` stays high until `lights = 0` and `btn = 0`, then the block returns to IDLE.
- **Timeout.** Lights out, no press, TIMEOUT = 2000.
  - `timeout` pulses on the cycle after the 2000th tick, with `time_out = 2000`.
  - `best_time` is unchanged and `valid` stays 0.
- **Simultaneous events.**
  - Press in the same cycle as a tick with `cnt = 41`: reports 41.
  - Press in the same cycle as `lights` dropping to 0 from ALL_ON: JUMP.
  - Press on the tick that would reach TIMEOUT: `valid` with `time_out = TIMEOUT - 1`, no `timeout`.
- **Reset and held button.**
  - Assert `rst` mid-TIMING with `btn` held high: all outputs return to their reset values and no pulse occurs.
  - After release, the held `btn` produces no press.
  - A following normal run reports correctly.
